// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler that shares one serial transmit line between NUM_REQ word producers.
// Frames each accepted word as a start bit (1), data MSB-first, then GAP_BITS idle (0) bits.
module serial_tx_scheduler #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned WORD_SIZE  = 27,
   parameter int unsigned BIT_CYCLES = 1,
   parameter int unsigned GAP_BITS   = 2,
   parameter int unsigned COUNT_W    = 16
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           serialOut,
   output logic                           busy,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic [COUNT_W-1:0]             word_count
);

   localparam int unsigned ID_W     = $clog2(NUM_REQ);
   localparam int unsigned CYC_W    = $clog2(BIT_CYCLES + 1);
   localparam int unsigned IDX_W    = $clog2(WORD_SIZE) + 1;
   localparam int unsigned GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

   typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

   state_t               state, state_nxt;
   logic [WORD_SIZE-1:0] shreg, shreg_nxt;
   logic [ID_W-1:0]      rr_ptr, rr_ptr_nxt;
   logic [ID_W-1:0]      grant_nxt;
   logic [ID_W-1:0]      winner;
   logic                 found;
   int unsigned          cand;
   logic                 ser_nxt;
   logic [COUNT_W-1:0]   count_nxt;
   logic [CYC_W-1:0]     cyc, cyc_nxt;
   logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
   logic                 bit_done;

   // Round-robin search: first valid index upward from rr_ptr+1, with wrap.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = 0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = (32'(rr_ptr) + i) % NUM_REQ;
         if (!found && req_valid[ID_W'(cand)]) begin
            found  = 1'b1;
            winner = ID_W'(cand);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && found) req_ready[winner] = 1'b1;
   end

   assign busy     = (state != IDLE);
   assign bit_done = (cyc == CYC_W'(BIT_CYCLES - 1));

   // Next-state and next-register logic; every register holds unless changed below.
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      rr_ptr_nxt  = rr_ptr;
      grant_nxt   = grant_id;
      ser_nxt     = serialOut;
      count_nxt   = word_count;
      cyc_nxt     = cyc;
      bit_idx_nxt = bit_idx;

      if (state != IDLE) cyc_nxt = bit_done ? '0 : cyc + CYC_W'(1);

      case (state)
         IDLE: begin
            ser_nxt = 1'b0;
            if (found) begin
               shreg_nxt  = req_data[32'(winner)*WORD_SIZE +: WORD_SIZE];
               rr_ptr_nxt = winner;
               grant_nxt  = winner;
               ser_nxt    = 1'b1;
               cyc_nxt    = '0;
               state_nxt  = START;
            end
         end
         START: begin
            if (bit_done) begin
               ser_nxt     = shreg[WORD_SIZE-1];
               shreg_nxt   = shreg << 1;
               bit_idx_nxt = IDX_W'(WORD_SIZE - 1);
               state_nxt   = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx == '0) begin
                  ser_nxt = 1'b0;
                  if (GAP_BITS > 0) begin
                     bit_idx_nxt = '0;
                     state_nxt   = GAP;
                  end else begin
                     count_nxt = word_count + COUNT_W'(1);
                     state_nxt = IDLE;
                  end
               end else begin
                  bit_idx_nxt = bit_idx - IDX_W'(1);
                  ser_nxt     = shreg[WORD_SIZE-1];
                  shreg_nxt   = shreg << 1;
               end
            end
         end
         GAP: begin
            ser_nxt = 1'b0;
            if (bit_done) begin
               if (bit_idx == IDX_W'(GAP_LAST)) begin
                  count_nxt = word_count + COUNT_W'(1);
                  state_nxt = IDLE;
               end else begin
                  bit_idx_nxt = bit_idx + IDX_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reset aborts any frame in flight; rr_ptr starts at the top so requester 0 wins first.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         shreg      <= '0;
         rr_ptr     <= ID_W'(NUM_REQ - 1);
         grant_id   <= '0;
         serialOut  <= 1'b0;
         word_count <= '0;
         cyc        <= '0;
         bit_idx    <= '0;
      end else begin
         state      <= state_nxt;
         shreg      <= shreg_nxt;
         rr_ptr     <= rr_ptr_nxt;
         grant_id   <= grant_nxt;
         serialOut  <= ser_nxt;
         word_count <= count_nxt;
         cyc        <= cyc_nxt;
         bit_idx    <= bit_idx_nxt;
      end
   end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed bench for serial_tx_scheduler: default, slow-bit/no-gap and narrow-counter instances.
module tb_serial_tx_scheduler;

   logic clk;
   logic reset;

   logic [3:0]     rv0, rv1, rv2;
   logic [107:0]   rd0, rd1, rd2;
   logic [3:0]     rdy0, rdy1, rdy2;
   logic           so0, so1, so2;
   logic           busy0, busy1, busy2;
   logic [1:0]     gid0, gid1, gid2;
   logic [15:0]    wc0, wc1;
   logic [3:0]     wc2;

   int tests;
   int failed;
   logic [26:0] dw [4];
   logic [27:0] f1;

   serial_tx_scheduler dut0 (
      .clock(clk), .reset(reset), .req_valid(rv0), .req_data(rd0), .req_ready(rdy0),
      .serialOut(so0), .busy(busy0), .grant_id(gid0), .word_count(wc0));

   serial_tx_scheduler #(.BIT_CYCLES(4), .GAP_BITS(0)) dut1 (
      .clock(clk), .reset(reset), .req_valid(rv1), .req_data(rd1), .req_ready(rdy1),
      .serialOut(so1), .busy(busy1), .grant_id(gid1), .word_count(wc1));

   serial_tx_scheduler #(.COUNT_W(4)) dut2 (
      .clock(clk), .reset(reset), .req_valid(rv2), .req_data(rd2), .req_ready(rdy2),
      .serialOut(so2), .busy(busy2), .grant_id(gid2), .word_count(wc2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered in the first cycle after accept; leaves in the IDLE cycle after the gap.
   task automatic frame0(input logic [26:0] d, input string tag);
      logic [29:0] f;
      f = {1'b1, d, 2'b00};
      for (int i = 29; i >= 0; i--) begin
         chk({tag, "_ser"}, 64'(so0), 64'(f[i]));
         chk({tag, "_busy"}, 64'(busy0), 64'd1);
         chk({tag, "_rdy"}, 64'(rdy0), 64'd0);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      reset  = 1'b1;
      rv0 = '0; rv1 = '0; rv2 = '0;
      rd0 = '0; rd1 = '0; rd2 = '0;
      dw[0] = 27'h1234567;
      dw[1] = 27'h5A5A5A5;
      dw[2] = 27'h0F0F0F1;
      dw[3] = 27'h7E00003;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_ser",   64'(so0),   64'd0);
      chk("rst_busy",  64'(busy0), 64'd0);
      chk("rst_gid",   64'(gid0),  64'd0);
      chk("rst_wc",    64'(wc0),   64'd0);
      chk("rst_rdy",   64'(rdy0),  64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Single word, data changed after accept must not affect the frame.
      rv0 = 4'b0001;
      rd0[26:0] = 27'h4000001;
      #1 chk("single_rdy", 64'(rdy0), 64'b0001);
      @(negedge clk);
      rv0 = '0;
      rd0[26:0] = 27'h2B3C4D5;
      frame0(27'h4000001, "single");
      chk("single_busy_end", 64'(busy0), 64'd0);
      chk("single_wc",       64'(wc0),   64'd1);
      chk("single_gid",      64'(gid0),  64'd0);
      chk("single_ser_end",  64'(so0),   64'd0);

      // All requesters valid: grants 0,1,2,3,0 exactly 31 cycles apart.
      do_reset();
      rv0 = 4'b1111;
      for (int i = 0; i < 4; i++) rd0[i*27 +: 27] = dw[i];
      for (int g = 0; g < 5; g++) begin
         #1 chk("rr_rdy", 64'(rdy0), 64'd1 << (g % 4));
         @(negedge clk);
         chk("rr_gid", 64'(gid0), 64'(g % 4));
         frame0(dw[g % 4], "rr_frame");
      end
      rv0 = '0;
      chk("rr_wc", 64'(wc0), 64'd5);

      // Round-robin skip: grant 1, then only 0 and 3 valid -> 3 then 0.
      do_reset();
      rv0 = 4'b0010;
      #1 chk("skip_rdy1", 64'(rdy0), 64'b0010);
      @(negedge clk);
      chk("skip_gid1", 64'(gid0), 64'd1);
      rv0 = 4'b1001;
      frame0(dw[1], "skip_f1");
      #1 chk("skip_rdy3", 64'(rdy0), 64'b1000);
      @(negedge clk);
      chk("skip_gid3", 64'(gid0), 64'd3);
      frame0(dw[3], "skip_f3");
      #1 chk("skip_rdy0", 64'(rdy0), 64'b0001);
      @(negedge clk);
      rv0 = '0;
      chk("skip_gid0", 64'(gid0), 64'd0);
      frame0(dw[0], "skip_f0");
      chk("skip_wc", 64'(wc0), 64'd3);

      // Reset 10 cycles after accept, in the middle of an all-ones data word.
      rv0 = 4'b0010;
      rd0[27 +: 27] = 27'h7FFFFFF;
      #1 chk("mid_rdy", 64'(rdy0), 64'b0010);
      @(negedge clk);
      rv0 = '0;
      repeat (9) @(negedge clk);
      chk("mid_ser_pre",  64'(so0),   64'd1);
      chk("mid_busy_pre", 64'(busy0), 64'd1);
      reset = 1'b0;
      #1;
      chk("mid_ser_rst",  64'(so0),   64'd0);
      chk("mid_busy_rst", 64'(busy0), 64'd0);
      chk("mid_wc_rst",   64'(wc0),   64'd0);
      chk("mid_gid_rst",  64'(gid0),  64'd0);
      chk("mid_rdy_rst",  64'(rdy0),  64'd0);
      @(negedge clk);
      reset = 1'b1;
      rv0 = 4'b0100;
      #1 chk("mid_rdy2", 64'(rdy0), 64'b0100);
      @(negedge clk);
      rv0 = '0;
      chk("mid_gid2", 64'(gid0), 64'd2);
      frame0(dw[2], "mid_frame");
      chk("mid_wc_end",   64'(wc0),   64'd1);
      chk("mid_busy_end", 64'(busy0), 64'd0);

      // BIT_CYCLES=4, GAP_BITS=0: 112 busy cycles, one idle cycle, next accept.
      rv1 = 4'b0001;
      rd1[26:0] = dw[1];
      f1 = {1'b1, dw[1]};
      #1 chk("slow_rdy", 64'(rdy1), 64'b0001);
      @(negedge clk);
      for (int b = 27; b >= 0; b--) begin
         for (int c = 0; c < 4; c++) begin
            chk("slow_ser",  64'(so1),   64'(f1[b]));
            chk("slow_busy", 64'(busy1), 64'd1);
            chk("slow_rdy0", 64'(rdy1),  64'd0);
            @(negedge clk);
         end
      end
      #1;
      chk("slow_busy_end", 64'(busy1), 64'd0);
      chk("slow_ser_end",  64'(so1),   64'd0);
      chk("slow_wc",       64'(wc1),   64'd1);
      chk("slow_rdy_next", 64'(rdy1),  64'b0001);
      rv1 = '0;
      @(negedge clk);

      // COUNT_W=4: 17 back-to-back frames wrap the count 15 -> 0 and end at 1.
      rv2 = 4'b0001;
      rd2[26:0] = dw[0];
      for (int f = 0; f < 17; f++) begin
         #1 chk("wrap_rdy", 64'(rdy2), 64'b0001);
         repeat (31) @(negedge clk);
         chk("wrap_wc", 64'(wc2), 64'((f + 1) % 16));
      end
      rv2 = '0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/serial_tx_scheduler.md
# serial_tx_scheduler

Round-robin scheduler that shares one serial transmit line between NUM_REQ word producers. It accepts one WORD_SIZE-bit word at a time over a valid/ready handshake and frames it as a start bit, the data MSB-first, then idle gap bits. It drives the same serial line format as the ROM-driven sender (line idles at 0), so producers other than the fixed message ROM can share the transmitter.

## Interface
- NUM_REQ, 4: number of requesters, at least 2.
- WORD_SIZE, 27: data bits per frame.
- BIT_CYCLES, 1: clock cycles per serial bit, at least 1.
- GAP_BITS, 2: idle (0) bits after each frame, at least 0.
- COUNT_W, 16: width of word_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a word pending.
- req_data  in  NUM_REQ*WORD_SIZE  word for requester i at [i*WORD_SIZE +: WORD_SIZE].
- req_ready  out  NUM_REQ  one-hot accept pulse, combinational.
- serialOut  out  1  registered serial line.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the most recently granted requester.
- word_count  out  COUNT_W  number of completed frames, wraps modulo 2^COUNT_W.

## Operation
- States: IDLE, START, DATA, GAP.
- **IDLE**
  - If any req_valid is high, select the winner by round-robin: the first valid index searching upward, with wrap, from rr_ptr+1.
  - req_ready[winner] is high in that cycle only.
  - At the clock edge, capture req_data[winner] into the shift register, set rr_ptr and grant_id to the winner, set serialOut to 1, and go to START.
  - With no valid request, serialOut stays 0.
- **START**
  - Hold serialOut at 1 for BIT_CYCLES cycles.
  - Then serialOut takes shift bit WORD_SIZE-1 and the state goes to DATA.
- **DATA**
  - Each bit is held for BIT_CYCLES cycles, MSB first.
  - After bit 0 completes: if GAP_BITS is greater than 0, serialOut goes to 0 and the state goes to GAP.
  - If GAP_BITS is 0, serialOut goes to 0, word_count increments, and the state goes to IDLE.
- **GAP**
  - serialOut is 0 for GAP_BITS*BIT_CYCLES cycles.
  - Then word_count increments and the state goes to IDLE.
- req_ready is low in every state except IDLE. A requester must hold req_valid and req_data stable until it sees req_ready.
- Data is captured at accept. Changes to req_data after the accept edge have no effect on the frame in flight.
- A req_valid that drops before it is granted is simply not served. No error is raised.
- Internal counters: a bit-cycle counter of width $clog2(BIT_CYCLES+1), and a bit index of width $clog2(WORD_SIZE)+1 that also counts gap bits.
- word_count wraps from 2^COUNT_W-1 to 0 silently.

## Timing
- **Reset** (reset low, asynchronous):
  - Outputs: serialOut=0, busy=0, grant_id=0, word_count=0, req_ready all 0.
  - Internal: state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - Reset asserted mid-frame aborts the frame immediately. No count is recorded and no partial bits follow.
- **Frame from accept edge t0**, with B = BIT_CYCLES, W = WORD_SIZE, G = GAP_BITS:
  - Start bit: serialOut=1 during cycles t0+1 through t0+B.
  - Data bit k (k = W-1 down to 0): cycles t0+1+(W-k)B through t0+(W-k+1)B.
  - Gap: cycles after the last data bit, (1+W)B+1 through (1+W+G)B.
- State returns to IDLE at edge t0+(1+W+G)B, and word_count updates on that same edge.
- The earliest next accept is in the IDLE cycle that follows, so the minimum frame period is (1+W+G)B+1 cycles. With default parameters this is 31 cycles.
- busy is high from t0+1 through the last gap cycle inclusive.

## Test plan
- **Single word:** req_valid=0001, req_data[0]=27'h4000001, default parameters.
  - Response: req_ready=0001 for 1 cycle, then serialOut = 1 (start), 1, 25 zeros, 1, then 0, 0 (gap). Then busy=0, word_count=1, grant_id=0.
- **All requesters valid continuously:**
  - Response: grant order 0,1,2,3,0, with accepts exactly 31 cycles apart and exactly one req_ready bit set per accept.
- **Round-robin skip:** grant requester 1 first, then assert only requesters 0 and 3.
  - Response: next grant is 3, then 0.
- **Reset mid-DATA:** assert reset 10 cycles after accept.
  - Response: serialOut, busy and word_count go to 0 asynchronously, before the next clock edge.
  - After release, with only requester 2 valid: grant_id=2 and a full frame follows.
- **BIT_CYCLES=4, GAP_BITS=0:**
  - Response: each bit held 4 cycles, busy high for 112 cycles, then one idle cycle before the next accept. word_count increments at frame end.
- **COUNT_W=4, 17 frames:**
  - Response: word_count wraps 15 to 0, ending at 1.
